// File: rtl/keypad_scanner_param.sv
// Matrix keypad scanner: active-low row strobing, press/release debounce,
// multi-key rejection, optional auto-repeat and a valid/ready event FIFO.
module keypad_scanner_param #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 200,
    parameter int REPEAT_RATE     = 50,
    parameter int FIFO_DEPTH      = 4,
    localparam int KW             = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [KW-1:0]   key_code,
    output logic            key_release,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int DIVW  = $clog2(SCAN_DIV);
    localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REPW  = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam int RATEW = $clog2(REPEAT_RATE + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int EW    = KW + 1;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ROWS-1:0]   row_out_q;
    logic [DIVW-1:0]   div_q, div_d;
    logic [COLS-1:0]   pat_q, pat_d;
    logic [KW-1:0]     code_q, code_d;
    logic [DBW-1:0]    db_q, db_d;
    logic [REPW-1:0]   rep_q, rep_d;
    logic [RATEW-1:0]  rate_q, rate_d;
    logic              held_q;

    logic [CW:0]       zero_cnt_s;
    logic [CW-1:0]     col_idx_s;
    logic [RW-1:0]     row_next_s;
    logic              push_s;
    logic              push_rel_s;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              valid_q;
    logic              ovf_q;
    logic              pop_s, full_s, wr_en_s, ovf_d;
    logic [EW-1:0]     head_s;

    // Count low columns and locate the last low one (unique when the count is 1).
    always_comb begin
        zero_cnt_s = '0;
        col_idx_s  = '0;
        for (int i = 0; i < COLS; i++) begin
            zero_cnt_s = zero_cnt_s + {{CW{1'b0}}, ~col_in[i]};
            col_idx_s  = col_in[i] ? col_idx_s : CW'(i);
        end
    end

    assign row_next_s = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

    // Scan / debounce / hold / release-debounce next-state logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        div_d      = div_q;
        pat_d      = pat_q;
        code_d     = code_q;
        db_d       = db_q;
        rep_d      = rep_q;
        rate_d     = rate_q;
        push_s     = 1'b0;
        push_rel_s = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIVW'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (zero_cnt_s == (CW+1)'(1)) begin
                        state_d = ST_DEBOUNCE;
                        pat_d   = col_in;
                        code_d  = KW'(row_q) * KW'(COLS) + KW'(col_idx_s);
                        db_d    = '0;
                    end else begin
                        row_d = row_next_s;
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_in == pat_q) begin
                    if (db_q + DBW'(1) == DBW'(DEBOUNCE_CYCLES)) begin
                        push_s  = 1'b1;
                        state_d = ST_HELD;
                        db_d    = '0;
                        rep_d   = '0;
                        rate_d  = '0;
                    end else begin
                        db_d = db_q + DBW'(1);
                    end
                end else begin
                    state_d = ST_SCAN;
                    row_d   = row_next_s;
                    db_d    = '0;
                end
            end
            ST_HELD: begin
                if (col_in != pat_q) begin
                    state_d = ST_REL_DB;
                    db_d    = '0;
                end else if (REPEAT_DELAY > 0) begin
                    // rep_q saturates at the initial delay; rate_q paces later repeats.
                    if (rep_q < REPW'(REPEAT_DELAY)) begin
                        rep_d  = rep_q + REPW'(1);
                        push_s = (rep_d == REPW'(REPEAT_DELAY));
                    end else if (rate_q + RATEW'(1) == RATEW'(REPEAT_RATE)) begin
                        rate_d = '0;
                        push_s = 1'b1;
                    end else begin
                        rate_d = rate_q + RATEW'(1);
                    end
                end else begin
                    rep_d = rep_q;
                end
            end
            ST_REL_DB: begin
                if (col_in == {COLS{1'b1}}) begin
                    if (db_q + DBW'(1) == DBW'(DEBOUNCE_CYCLES)) begin
                        push_s     = 1'b1;
                        push_rel_s = 1'b1;
                        state_d    = ST_SCAN;
                        row_d      = row_next_s;
                        db_d       = '0;
                    end else begin
                        db_d = db_q + DBW'(1);
                    end
                end else if (col_in == pat_q) begin
                    state_d = ST_HELD;
                    db_d    = '0;
                end else begin
                    db_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
                row_d   = '0;
                div_d   = '0;
                db_d    = '0;
            end
        endcase
    end

    // Scanner state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SCAN;
            row_q     <= '0;
            row_out_q <= ~(ROWS'(1));
            div_q     <= '0;
            pat_q     <= '0;
            code_q    <= '0;
            db_q      <= '0;
            rep_q     <= '0;
            rate_q    <= '0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_out_q <= ~(ROWS'(1) << row_d);
            div_q     <= div_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            db_q      <= db_d;
            rep_q     <= rep_d;
            rate_q    <= rate_d;
            held_q    <= (state_d == ST_HELD) || (state_d == ST_REL_DB);
        end
    end

    assign pop_s   = valid_q & key_ready;
    assign full_s  = (cnt_q == CNTW'(FIFO_DEPTH));
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign ovf_d   = push_s & full_s & ~pop_s;

    // FIFO occupancy update.
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= {push_rel_s, code_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    assign head_s      = valid_q ? mem_q[rd_ptr_q] : '0;
    assign key_code    = head_s[KW-1:0];
    assign key_release = head_s[KW];
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign overflow    = ovf_q;
    assign row_out     = row_out_q;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Self-checking bench for keypad_scanner_param: a keypad model drives col_in from
// row_out, expected events go into a scoreboard queue checked as the DUT emits them.
module tb_keypad_scanner_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ovf_cnt = 0;
    logic [4:0] exp_q[$];
    int         ev_cyc[$];

    logic key_down;
    int   krow, kcol;
    logic multi_en;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } key_vec_t;
    key_vec_t vecs[4];

    keypad_scanner_param #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(16),
        .REPEAT_DELAY(200), .REPEAT_RATE(50), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_release(key_release), .key_valid(key_valid),
        .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a held key pulls its column low only while its row is strobed.
    always_comb begin
        col_in = 4'b1111;
        if (multi_en && !row_out[1]) col_in = 4'b1001;
        else if (key_down && !row_out[krow]) col_in = ~(4'b0001 << kcol);
    end

    // Scoreboard: compare each consumed event against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_cnt = ovf_cnt + 1;
            if (key_valid && key_ready) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event: got code=%0d rel=%0d expected no event",
                             key_code, key_release);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    ev_cyc.push_back(cyc);
                    if ({key_release, key_code} !== e) begin
                        errors = errors + 1;
                        $display("FAIL event: got rel=%0d code=%0d expected rel=%0d code=%0d",
                                 key_release, key_code, e[4], e[3:0]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_held(input string nm, input logic val, input int budget);
        int n = 0;
        while (key_held !== val && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, key_held, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int base;
        logic [3:0] er;
        logic [3:0] seen;
        logic held_seen, valid_seen;

        vecs[0] = '{1, 2, 4'd6};
        vecs[1] = '{0, 0, 4'd0};
        vecs[2] = '{3, 3, 4'd15};
        vecs[3] = '{2, 1, 4'd9};

        rst = 1'b1; key_ready = 1'b1; key_down = 1'b0; multi_en = 1'b0;
        krow = 0; kcol = 0;
        #1;
        chk("rst_row_out", row_out, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_release", key_release, 0);
        chk("rst_held", key_held, 0);
        chk("rst_overflow", overflow, 0);
        tick(3);
        rst = 1'b0;

        // Idle rotation: one row every four clocks.
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            er = ~(4'b0001 << ((k / 4) % 4));
            chk("rotate_row", row_out, er);
        end
        tick(84);
        chk("idle_valid", key_valid, 0);

        // Table-driven press/release of several keys.
        for (int i = 0; i < 4; i++) begin
            krow = vecs[i].r; kcol = vecs[i].c;
            exp_q.push_back({1'b0, vecs[i].code});
            key_down = 1'b1;
            wait_empty("press_seen", 200);
            chk("press_held", key_held, 1);
            exp_q.push_back({1'b1, vecs[i].code});
            key_down = 1'b0;
            c0 = cyc;
            base = ev_cyc.size();
            wait_empty("release_seen", 200);
            if (i == 0) chk("release_latency", ev_cyc[base] - c0, 17);
            tick(2);
            chk("released_held", key_held, 0);
            chk("empty_code", {key_release, key_code}, 0);
        end

        // Bounce during press debounce: aligned to the start of row 2.
        krow = 2; kcol = 3;
        begin
            int n = 0;
            while (row_out == 4'b1011 && n < 40) begin tick(1); n++; end
            while (row_out != 4'b1011 && n < 40) begin tick(1); n++; end
        end
        key_down = 1'b1;
        tick(9);
        key_down = 1'b0;
        tick(1);
        key_down = 1'b1;
        c0 = cyc;
        chk("bounce_no_event", key_valid, 0);
        chk("bounce_not_held", key_held, 0);
        exp_q.push_back({1'b0, 4'd11});
        base = ev_cyc.size();
        wait_empty("bounce_press", 200);
        chk("bounce_stable_16", (ev_cyc.size() > base) && (ev_cyc[base] - c0 >= 17), 1);
        tick(10);
        exp_q.push_back({1'b1, 4'd11});
        key_down = 1'b0;
        wait_empty("bounce_release", 200);

        // Short release that re-matches returns to HELD without an event.
        krow = 1; kcol = 1;
        exp_q.push_back({1'b0, 4'd5});
        key_down = 1'b1;
        wait_empty("reldb_press", 200);
        key_down = 1'b0;
        tick(3);
        key_down = 1'b1;
        tick(3);
        chk("reldb_back_held", key_held, 1);
        chk("reldb_no_event", key_valid, 0);
        exp_q.push_back({1'b1, 4'd5});
        key_down = 1'b0;
        wait_empty("reldb_release", 200);

        // Auto-repeat on key 0.
        krow = 0; kcol = 0;
        base = ev_cyc.size();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 4'd0});
        key_down = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() > 4 && n < 200) begin tick(1); n++; end
        end
        tick(360);
        exp_q.push_back({1'b1, 4'd0});
        key_down = 1'b0;
        wait_empty("repeat_events", 400);
        if (ev_cyc.size() >= base + 6) begin
            chk("repeat_first", ev_cyc[base + 1] - ev_cyc[base], 200);
            chk("repeat_2", ev_cyc[base + 2] - ev_cyc[base + 1], 50);
            chk("repeat_3", ev_cyc[base + 3] - ev_cyc[base + 2], 50);
            chk("repeat_4", ev_cyc[base + 4] - ev_cyc[base + 3], 50);
        end else begin
            chk("repeat_count", ev_cyc.size() - base, 6);
        end

        // Overflow: four queued events, the fifth is dropped.
        key_ready = 1'b0;
        ovf_cnt = 0;
        krow = 0; kcol = 1;
        key_down = 1'b1; wait_held("ovf_a_press", 1'b1, 200);
        key_down = 1'b0; wait_held("ovf_a_rel", 1'b0, 200);
        krow = 2; kcol = 3;
        key_down = 1'b1; wait_held("ovf_b_press", 1'b1, 200);
        key_down = 1'b0; wait_held("ovf_b_rel", 1'b0, 200);
        chk("ovf_none_yet", ovf_cnt, 0);
        krow = 3; kcol = 0;
        key_down = 1'b1; wait_held("ovf_c_press", 1'b1, 200);
        tick(2);
        chk("ovf_pulse", ovf_cnt, 1);
        chk("ovf_valid", key_valid, 1);
        exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b1, 4'd1});
        exp_q.push_back({1'b0, 4'd11});
        exp_q.push_back({1'b1, 4'd11});
        key_ready = 1'b1;
        wait_empty("ovf_drain", 20);
        tick(2);
        chk("ovf_drained_valid", key_valid, 0);
        exp_q.push_back({1'b1, 4'd12});
        key_down = 1'b0;
        wait_empty("ovf_c_release", 200);
        chk("ovf_total", ovf_cnt, 1);

        // Two columns low on one row is ignored and scanning continues.
        multi_en = 1'b1;
        seen = 4'b0000; held_seen = 1'b0; valid_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            seen = seen | ~row_out;
            held_seen = held_seen | key_held;
            valid_seen = valid_seen | key_valid;
        end
        chk("multi_rows_seen", seen, 4'b1111);
        chk("multi_no_held", held_seen, 0);
        chk("multi_no_valid", valid_seen, 0);
        multi_en = 1'b0;

        // Asynchronous reset while HELD with a pending event.
        key_ready = 1'b0;
        krow = 2; kcol = 2;
        key_down = 1'b1;
        wait_held("rst_hold_press", 1'b1, 200);
        tick(1);
        chk("pre_rst_valid", key_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_row_out", row_out, 4'b1110);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_code", {key_release, key_code}, 0);
        chk("mid_rst_overflow", overflow, 0);
        key_down = 1'b0;
        tick(2);
        rst = 1'b0;
        key_ready = 1'b1;
        tick(5);
        chk("post_rst_valid", key_valid, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_param.md
Name: keypad_scanner_param

Overview:
Parametrised matrix-keypad scanner for ROWS x COLS keypads. It drives active-low row strobes and samples active-low column inputs. It debounces both press and release, rejects multi-key (ghosting) patterns and generates optional auto-repeat. Press, repeat and release events are queued in a small FIFO with a valid/ready interface, so downstream logic (UART/display/FSM) can consume keys at its own pace.

Parameters:
ROWS, 4, number of row strobes (2..8)
COLS, 4, number of column inputs (2..8)
SCAN_DIV, 4, clk cycles each row is driven before columns are sampled (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (>=1)
REPEAT_DELAY, 200, cycles held before the first repeat event; 0 disables auto-repeat
REPEAT_RATE, 50, cycles between subsequent repeat events (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
col_in  in  COLS  column lines, active low, already synchronised externally
row_out  out  ROWS  row strobes, exactly one bit low while scanning
key_code  out  KW=$clog2(ROWS*COLS)  FIFO head code = row*COLS + col
key_release  out  1  FIFO head type: 1 = release, 0 = press/repeat
key_valid  out  1  FIFO not empty
key_ready  in  1  consumer accepts head when key_valid & key_ready
key_held  out  1  high in HELD and REL_DB states
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset values: state SCAN, row index 0, row_out = all ones except bit 0 low. key_valid=0, key_code=0, key_release=0, key_held=0, overflow=0. FIFO empty. All counters 0.
- Column index c = position of the single 0 bit in col_in.
- SCAN: drive row r low for SCAN_DIV cycles and sample col_in on the last cycle.
  - All ones: advance r (wrap ROWS-1 -> 0).
  - Exactly one zero: latch r, c and pattern; debounce counter=0; go DEBOUNCE. Row stays driven.
  - More than one zero: multi-key; ignore and advance r.
- DEBOUNCE: each cycle col_in == latched pattern increments the counter.
  - Any mismatch: return to SCAN and advance r; no event.
  - Counter reaches DEBOUNCE_CYCLES: push {0, code}, clear repeat counter, go HELD.
- HELD: repeat counter increments every cycle.
  - If REPEAT_DELAY>0, push {0, code} when the counter hits REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - col_in != latched pattern: go REL_DB with counter=0.
- REL_DB:
  - col_in all ones: counter increments; at DEBOUNCE_CYCLES push {1, code}, go SCAN and advance r.
  - col_in == latched pattern: return to HELD; repeat counter keeps its value (no reset, no event).
  - Any other pattern: counter=0, stay in REL_DB.
- Repeat counter is frozen while in REL_DB.
- FIFO:
  - Write occurs in the cycle the event is generated; key_valid rises the next cycle.
  - Pop when key_valid & key_ready; the head updates the next cycle.
  - Push while full without a pop in the same cycle: event dropped, overflow=1 for one cycle.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - Simultaneous push and pop when empty: key_valid rises next cycle.
- key_code and key_release are 0 whenever the FIFO is empty.
- Reset mid-operation: reset asynchronously returns everything to reset values and discards pending FIFO contents.
- Only one key is tracked at a time; other keys are ignored until release completes.

Test Plan:
1. Defaults; col_in=4'b1111 for 100 cycles -> row_out rotates 1110,1101,1011,0111 every 4 cycles; key_valid stays 0.
2. Hold col_in=4'b1011 while row 1 (row_out=1101) is low, key_ready=1 -> one press event with key_code=6, key_release=0, key_held=1. Release to 1111 for 16 cycles -> release event code 6 with key_release=1.
3. Press with a bounce (matches 5 cycles, 1111 for 1 cycle, then stable) -> no event until 16 consecutive stable cycles; in every case exactly one press event.
4. Hold key code 0 for 400 cycles with key_ready=1 -> press, repeats at +200, +250, +300, +350 cycles after the press event, then a release after the key is released.
5. key_ready=0; generate 5 press/release events -> first 4 queued, overflow pulses once on the 5th. Drain 4 in order with correct codes and types.
6. col_in=4'b1001 on a row (two columns) -> no event, scan continues. Assert rst in HELD -> all outputs return to reset values and the FIFO is empty.
